// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and receiver.
// Holds oversampling constants and the serial FSM state encoding.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART serialiser.
// Registered full/empty; a push while full is dropped even if a pop occurs.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        r_full;
  logic        r_empty;
  logic [AW:0] w_wr_nx;
  logic [AW:0] w_rd_nx;
  logic        w_do_push;
  logic        w_do_pop;

  assign w_do_push = i_push && !r_full;
  assign w_do_pop  = i_pop && !r_empty;
  assign o_dout    = r_mem[r_rd[AW-1:0]];
  assign o_full    = r_full;
  assign o_empty   = r_empty;

  // Next pointer values after this cycle's accepted push/pop.
  always_comb begin
    w_wr_nx = r_wr;
    w_rd_nx = r_rd;
    if (w_do_push) w_wr_nx = r_wr + 1'b1;
    if (w_do_pop)  w_rd_nx = r_rd + 1'b1;
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end

  // Pointers and flags, flags computed from next pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wr    <= w_wr_nx;
      r_rd    <= w_rd_nx;
      r_empty <= (w_wr_nx == w_rd_nx);
      r_full  <= (w_wr_nx[AW] != w_rd_nx[AW]) &&
                 (w_wr_nx[AW-1:0] == w_rd_nx[AW-1:0]);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB first, timed by a 16x baud tick.
// Frames are sent back-to-back while the FIFO holds bytes.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STOP_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int TW = (STOP_TICKS > OVERSAMPLE) ?
                      $clog2(STOP_TICKS) : $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
  localparam logic [2:0]    BITS_LAST = 3'(DATA_BITS - 1);

  tx_state_t     r_state;
  logic [TW-1:0] r_tick_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          w_pop;
  logic [7:0]    w_dout;
  logic          w_full;
  logic          w_empty;
  logic          w_stop_end;

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (valid),
    .i_pop   (w_pop),
    .i_din   (data_in),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_stop_end = (r_state == STOP) && tick &&
                      (r_tick_cnt == STOP_LAST);
  assign w_pop = !w_empty &&
                 ((r_state == IDLE) || w_stop_end);
  assign ready = !w_full;
  assign tx    = r_tx;
  assign busy  = (r_state != IDLE) || !w_empty;

  // Frame sequencer: state, counters, shift register and line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_shift    <= w_dout;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b0;
            r_state    <= START;
          end
        end
        START: begin
          if (tick) begin
            if (r_tick_cnt == BIT_LAST) begin
              r_tick_cnt <= '0;
              r_tx       <= r_shift[0];
              r_state    <= DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (r_tick_cnt == BIT_LAST) begin
              r_tick_cnt <= '0;
              r_shift    <= {1'b0, r_shift[7:1]};
              if (r_bit_cnt == BITS_LAST) begin
                r_tx    <= 1'b1;
                r_state <= STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_tx      <= r_shift[1];
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (r_tick_cnt == STOP_LAST) begin
              r_tick_cnt <= '0;
              if (!w_empty) begin
                r_shift   <= w_dout;
                r_bit_cnt <= '0;
                r_tx      <= 1'b0;
                r_state   <= START;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter.
// A line monitor rebuilds frames from tx and checks them against pushed bytes.
module tb_uart_transmitter;

  logic       clk = 0;
  logic       rst = 1;
  logic       tick = 0;
  logic [7:0] data1 = 0;
  logic       valid1 = 0;
  logic       ready1, tx1, busy1;
  logic [7:0] data2 = 0;
  logic       valid2 = 0;
  logic       ready2, tx2, busy2;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb[$];
  int         gap_q[$];
  int         nframes = 0;

  int tick_en = 0;
  int tick_period = 4;
  int tcnt = 0;

  uart_transmitter #(.DEPTH(4), .STOP_TICKS(16)) dut (
    .clk(clk), .rst(rst), .tick(tick), .data_in(data1),
    .valid(valid1), .ready(ready1), .tx(tx1), .busy(busy1)
  );

  uart_transmitter #(.DEPTH(4), .STOP_TICKS(32)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .data_in(data2),
    .valid(valid2), .ready(ready2), .tx(tx2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Baud tick: one clk wide every tick_period clocks.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tick_en == 0) begin
        tick = 0;
        tcnt = 0;
      end else if (tcnt >= tick_period - 1) begin
        tick = 1;
        tcnt = 0;
      end else begin
        tick = 0;
        tcnt++;
      end
    end
  end

  // Line monitor: sample tx on each tick, rebuild the frame.
  int         m_in = 0;
  int         m_k = 0;
  int         m_gap = 0;
  int         m_bad = 0;
  int         m_b, m_ph;
  logic [7:0] m_byte;
  logic [7:0] m_exp;

  always @(negedge clk) begin
    if (rst) begin
      m_in  = 0;
      m_gap = 0;
    end else begin
      if (m_in == 0 && tx1 == 1'b0) begin
        m_in   = 1;
        m_k    = 0;
        m_bad  = 0;
        m_byte = 0;
        gap_q.push_back(m_gap);
        m_gap  = 0;
      end else if (m_in == 0) begin
        m_gap++;
      end
      if (m_in != 0 && tick) begin
        m_b  = m_k / 16;
        m_ph = m_k % 16;
        if (m_b == 0) begin
          if (tx1 !== 1'b0) m_bad++;
        end else if (m_b <= 8) begin
          if (m_ph == 0) m_byte[m_b-1] = tx1;
          else if (tx1 !== m_byte[m_b-1]) m_bad++;
        end else begin
          if (tx1 !== 1'b1) m_bad++;
        end
        m_k++;
        if (m_k == 160) begin
          m_in = 0;
          nframes++;
          chk("frame_shape", m_bad, 0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got frame %02h expected none",
                     m_byte);
          end else begin
            m_exp = sb.pop_front();
            chk("frame_byte", m_byte, m_exp);
          end
        end
      end
    end
  end

  function automatic logic exp_level(input logic [7:0] b,
                                     input int k);
    if (k < 16) return 1'b0;
    if (k < 144) return b[(k - 16) / 16];
    return 1'b1;
  endfunction

  task automatic push_byte(input bit sel, input logic [7:0] b);
    int t;
    t = 0;
    @(posedge clk);
    #1;
    while ((sel ? ready2 : ready1) !== 1'b1 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 5000) chk("push_timeout", t, 0);
    if (sel) begin
      data2 = b;
      valid2 = 1;
    end else begin
      data1 = b;
      valid1 = 1;
    end
    @(posedge clk);
    if (!sel) sb.push_back(b);
    #1;
    valid1 = 0;
    valid2 = 0;
  endtask

  // Push one byte and check every tick of the frame plus its length.
  task automatic frame_check(input bit sel, input logic [7:0] b,
                             input int stop_t, input string nm);
    int k, t, bad;
    k = 0;
    t = 0;
    bad = 0;
    push_byte(sel, b);
    @(negedge clk);
    while ((sel ? tx2 : tx1) === 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_start_seen"}, (t < 1000), 1);
    t = 0;
    while (t < 40000) begin
      if ((sel ? busy2 : busy1) !== 1'b1) break;
      if (tick) begin
        if ((sel ? tx2 : tx1) !== exp_level(b, k)) bad++;
        k++;
      end
      @(negedge clk);
      t++;
    end
    chk({nm, "_bits"}, bad, 0);
    chk({nm, "_len_ticks"}, k, 144 + stop_t);
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    @(posedge clk);
    #1;
    while ((busy1 || m_in != 0) && t < 30000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({nm, "_idle_timeout"}, (t >= 30000), 0);
  endtask

  initial begin
    int acc, f0, t;
    logic a;
    logic [7:0] r;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_ready", ready1, 1);
    chk("rst_tx_stop32", tx2, 1);
    rst = 0;
    tick_en = 1;
    tick_period = 4;

    // Single 0x55 frame, 16-tick bits, 160 ticks total.
    frame_check(0, 8'h55, 16, "t1_55");
    wait_idle("t1");

    // Two stop bits on the second instance.
    frame_check(1, 8'h81, 32, "t5_81");

    // Fixed then random bytes at varied baud rates.
    frame_check(0, 8'hA3, 16, "t2_a3");
    frame_check(0, 8'h00, 16, "t2_00");
    frame_check(0, 8'hFF, 16, "t2_ff");
    wait_idle("t2");
    for (int i = 0; i < 16; i++) begin
      tick_period = $urandom_range(1, 5);
      push_byte(0, 8'($urandom));
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end
    wait_idle("rand");

    // Stalled tick: DEPTH+1 bytes accepted, then back-to-back frames.
    tick_en = 0;
    f0 = nframes;
    acc = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      data1 = 8'($urandom);
      valid1 = 1;
      a = ready1;
      r = data1;
      @(posedge clk);
      if (a) begin
        sb.push_back(r);
        acc++;
      end
      #1;
    end
    valid1 = 0;
    chk("t3_accepted", acc, 5);
    chk("t3_ready_low", ready1, 0);
    chk("t3_tx_held", tx1, 0);
    tick_period = 3;
    tick_en = 1;
    wait_idle("t3");
    chk("t3_frames", nframes - f0, 5);
    for (int i = 1; i < 5; i++)
      if (f0 + i < gap_q.size())
        chk("t3_gap", gap_q[f0 + i], 0);

    // Mid-frame reset during data bit 3 of 0x0F.
    tick_period = 2;
    push_byte(0, 8'h0F);
    t = 0;
    while (!(m_in != 0 && m_k >= 72) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    chk("t4_reach_bit3", (t < 5000), 1);
    #1;
    rst = 1;
    sb.delete();
    @(posedge clk);
    #1;
    chk("t4_tx", tx1, 1);
    chk("t4_busy", busy1, 0);
    chk("t4_ready", ready1, 1);
    rst = 0;
    frame_check(0, 8'h3C, 16, "t4_after");
    wait_idle("t4");

    // Continuous pushes: drops while full, even on pop edges.
    tick_period = 2;
    f0 = nframes;
    acc = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 1500; i++) begin
      data1 = 8'($urandom);
      valid1 = 1;
      a = ready1;
      r = data1;
      @(posedge clk);
      if (a) begin
        sb.push_back(r);
        acc++;
      end
      #1;
    end
    valid1 = 0;
    wait_idle("t6");
    chk("t6_frames", nframes - f0, acc);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
